// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the single-beat AXI4-Lite command master.
package axi_lite_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA, ST_DONE
  } state_e;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_TMO     = 1;
  localparam int STAT_BERR    = 2;
  localparam int STAT_RESP_LO = 4;
  localparam int STAT_IRQ     = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  function automatic logic [31:0] pack_status(input logic busy, input logic tmo,
                                              input logic berr, input logic [1:0] resp,
                                              input logic irq);
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]            = busy;
    s[STAT_TMO]             = tmo;
    s[STAT_BERR]            = berr;
    s[STAT_RESP_LO +: 2]    = resp;
    s[STAT_IRQ]             = irq;
    return s;
  endfunction

endpackage

// File: rtl/axi_lite_timeout.sv
// Loadable cycle counter; expired_o fires on the LIMIT-th enabled cycle after a load.
module axi_lite_timeout #(
  parameter int unsigned LIMIT = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Host command -> single-beat AXI4-Lite read/write. Define AXI_LITE_MASTER_TIMEOUT_EN
// to bound every AXI channel wait by DEFAULT_TIMEOUT cycles.
module axi_lite_cmd_master
  import axi_lite_master_pkg::*;
#(
  parameter int          INVERT_AXI_RESET = 0,
  parameter int          ADDR_WIDTH       = 32,
  parameter int          INTERRUPT_WIDTH  = 32,
  parameter int unsigned DEFAULT_TIMEOUT  = 100000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cmd_en,
  output logic                       o_cmd_ack,
  output logic                       o_cmd_error,
  output logic [31:0]                o_cmd_status,
  output logic                       o_cmd_interrupt,
  input  logic [ADDR_WIDTH-1:0]      i_cmd_addr,
  input  logic                       i_cmd_wr_rd,
  input  logic [3:0]                 i_cmd_byte_en,
  input  logic [31:0]                i_cmd_data_count,
  input  logic [31:0]                i_cmd_data,
  output logic [31:0]                o_cmd_data,
  output logic [3:0]                 o_awid,
  output logic [ADDR_WIDTH-1:0]      o_awaddr,
  output logic [2:0]                 o_awsize,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [3:0]                 o_wid,
  output logic [31:0]                o_wdata,
  output logic [3:0]                 o_wstrobe,
  output logic                       o_wlast,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  input  logic [3:0]                 i_bid,
  input  logic [1:0]                 i_bresp,
  input  logic                       i_bvalid,
  output logic                       o_bready,
  output logic [3:0]                 o_arid,
  output logic [ADDR_WIDTH-1:0]      o_araddr,
  output logic [7:0]                 o_arlen,
  output logic [2:0]                 o_arsize,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  input  logic [3:0]                 i_rid,
  input  logic [31:0]                i_rdata,
  input  logic [1:0]                 i_rresp,
  input  logic [3:0]                 i_rstrobe,
  input  logic                       i_rlast,
  input  logic                       i_rvalid,
  output logic                       o_rready,
  input  logic [INTERRUPT_WIDTH-1:0] i_interrupts
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  berr_q, berr_d;
  logic                  tmo_q, tmo_d;
  logic                  awv_q, awv_d;
  logic                  wv_q, wv_d;
  logic                  arv_q, arv_d;
  logic                  irq_q;
  logic                  waiting;
  logic                  tmo_expired;

  // Counter runs only while parked on an AXI channel; IDLE holds it cleared.
  assign waiting = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  axi_lite_timeout #(.LIMIT(DEFAULT_TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_q == ST_IDLE),
    .en_i      (waiting),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{i_bid, i_rid, i_rstrobe, i_rlast, i_cmd_data_count,
                       (INVERT_AXI_RESET != 0), (DEFAULT_TIMEOUT != 0)};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    berr_d  = berr_q;
    tmo_d   = tmo_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    arv_d   = arv_q;
    case (state_q)
      ST_IDLE: if (i_cmd_en) begin
        addr_d  = i_cmd_addr;
        be_d    = i_cmd_byte_en;
        wdata_d = i_cmd_data;
        resp_d  = RESP_OKAY;
        berr_d  = 1'b0;
        tmo_d   = 1'b0;
        if (i_cmd_wr_rd) begin
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = ST_WR_REQ;
        end else begin
          arv_d   = 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (i_awready) awv_d = 1'b0;
        if (i_wready)  wv_d  = 1'b0;
        if ((!awv_q || i_awready) && (!wv_q || i_wready))
          state_d = ST_WR_RESP;
      end
      ST_WR_RESP: if (i_bvalid) begin
        resp_d  = i_bresp;
        berr_d  = (i_bresp != RESP_OKAY);
        state_d = ST_DONE;
      end
      ST_RD_REQ: if (i_arready) begin
        arv_d   = 1'b0;
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: if (i_rvalid) begin
        rdata_d = i_rdata;
        resp_d  = i_rresp;
        berr_d  = (i_rresp != RESP_OKAY);
        state_d = ST_DONE;
      end
      ST_DONE: if (!i_cmd_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Expiry overrides any handshake landing on the same edge.
    if (tmo_expired) begin
      awv_d   = 1'b0;
      wv_d    = 1'b0;
      arv_d   = 1'b0;
      tmo_d   = 1'b1;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      berr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      berr_q  <= berr_d;
      tmo_q   <= tmo_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      irq_q   <= |i_interrupts;
    end
  end

  assign o_cmd_ack       = (state_q == ST_DONE);
  assign o_cmd_error     = o_cmd_ack && (berr_q || tmo_q);
  assign o_cmd_status    = pack_status(waiting, tmo_q, berr_q, resp_q, irq_q);
  assign o_cmd_interrupt = irq_q;
  assign o_cmd_data      = rdata_q;

  assign o_awid    = 4'd0;
  assign o_awaddr  = addr_q;
  assign o_awsize  = AXI_SIZE_4B;
  assign o_awvalid = awv_q;
  assign o_wid     = 4'd0;
  assign o_wdata   = wdata_q;
  assign o_wstrobe = be_q;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = wv_q;
  assign o_bready  = (state_q == ST_WR_RESP);
  assign o_arid    = 4'd0;
  assign o_araddr  = addr_q;
  assign o_arlen   = 8'd0;
  assign o_arsize  = AXI_SIZE_4B;
  assign o_arvalid = arv_q;
  assign o_rready  = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench: a driver issues directed commands and queues expectations, a
// monitor checks AXI beats and completions; a small reactive slave drives the bus.
module tb_axi_lite_cmd_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_cmd_en = 1'b0;
  logic        o_cmd_ack, o_cmd_error, o_cmd_interrupt;
  logic [31:0] o_cmd_status, o_cmd_data;
  logic [31:0] i_cmd_addr = '0;
  logic        i_cmd_wr_rd = 1'b0;
  logic [3:0]  i_cmd_byte_en = '0;
  logic [31:0] i_cmd_data_count = '0;
  logic [31:0] i_cmd_data = '0;
  logic [3:0]  o_awid, o_wid, o_arid, o_wstrobe;
  logic [31:0] o_awaddr, o_araddr, o_wdata;
  logic [2:0]  o_awsize, o_arsize;
  logic [7:0]  o_arlen;
  logic        o_awvalid, o_wvalid, o_wlast, o_bready, o_arvalid, o_rready;
  logic        i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
  logic        i_arready = 1'b0, i_rvalid = 1'b0, i_rlast = 1'b1;
  logic [3:0]  i_bid = '0, i_rid = '0, i_rstrobe = 4'hF;
  logic [1:0]  i_bresp = '0, i_rresp = '0;
  logic [31:0] i_rdata = '0;
  logic [31:0] i_interrupts = '0;

  axi_lite_cmd_master #(.DEFAULT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_cmd_en(i_cmd_en), .o_cmd_ack(o_cmd_ack),
    .o_cmd_error(o_cmd_error), .o_cmd_status(o_cmd_status),
    .o_cmd_interrupt(o_cmd_interrupt), .i_cmd_addr(i_cmd_addr),
    .i_cmd_wr_rd(i_cmd_wr_rd), .i_cmd_byte_en(i_cmd_byte_en),
    .i_cmd_data_count(i_cmd_data_count), .i_cmd_data(i_cmd_data),
    .o_cmd_data(o_cmd_data), .o_awid(o_awid), .o_awaddr(o_awaddr),
    .o_awsize(o_awsize), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrobe(o_wstrobe), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .o_arid(o_arid),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rid(i_rid),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rstrobe(i_rstrobe),
    .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .i_interrupts(i_interrupts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    logic [31:0] status;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave configuration, written by the driver only.
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
  bit          cfg_ar_never = 1'b0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [31:0] cfg_rdata = '0;

  // Reactive slave: readies after a programmable number of valid cycles,
  // responses one cycle after the address/data handshakes.
  initial begin
    bit p_aw, p_w, p_b, p_ar, p_r, g_aw, g_w, g_ar;
    int aw_wait, w_wait, ar_wait;
    {p_aw, p_w, p_b, p_ar, p_r, g_aw, g_w, g_ar} = '0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        {p_aw, p_w, p_b, p_ar, p_r, g_aw, g_w, g_ar} = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        continue;
      end
      if (p_aw) g_aw = 1;
      if (p_w)  g_w  = 1;
      if (p_ar) g_ar = 1;
      if (p_b)  i_bvalid = 0;
      if (p_r)  i_rvalid = 0;
      if (g_aw && g_w && !i_bvalid) begin
        i_bvalid = 1; i_bresp = cfg_bresp; g_aw = 0; g_w = 0;
      end
      if (g_ar && !i_rvalid) begin
        i_rvalid = 1; i_rdata = cfg_rdata; i_rresp = cfg_rresp; g_ar = 0;
      end
      i_awready = o_awvalid && (aw_wait >= cfg_aw_dly);
      i_wready  = o_wvalid  && (w_wait  >= cfg_w_dly);
      i_arready = o_arvalid && !cfg_ar_never && (ar_wait >= cfg_ar_dly);
      aw_wait = (o_awvalid && !i_awready) ? aw_wait + 1 : 0;
      w_wait  = (o_wvalid  && !i_wready)  ? w_wait + 1  : 0;
      ar_wait = (o_arvalid && !i_arready) ? ar_wait + 1 : 0;
      p_aw = o_awvalid && i_awready;
      p_w  = o_wvalid  && i_wready;
      p_ar = o_arvalid && i_arready;
      p_b  = i_bvalid  && o_bready;
      p_r  = i_rvalid  && o_rready;
    end
  end

  // Monitor: checks every AXI beat and every completion against the queues.
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin ack_prev = 0; continue; end
      if (o_awvalid && i_awready) begin
        if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else check("awaddr", o_awaddr, exp_aw_q.pop_front());
      end
      if (o_wvalid && i_wready) begin
        if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
        else check("wdata_strb", {o_wstrobe, o_wdata}, exp_w_q.pop_front());
      end
      if (o_arvalid && i_arready) begin
        if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else check("araddr", o_araddr, exp_ar_q.pop_front());
      end
      if (o_cmd_ack && !ack_prev) begin
        if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("cmd_error", o_cmd_error, e.err);
          check("cmd_status", o_cmd_status, e.status);
          if (e.chk_data) check("cmd_data", o_cmd_data, e.data);
        end
      end
      ack_prev = o_cmd_ack;
    end
  end

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data, input exp_t e, input bit drop_early,
                         output int aw_hi, output int w_hi, output int ar_hi, output int lat);
    bit done;
    if (wr) begin
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({be, data});
    end else exp_ar_q.push_back(addr);
    exp_q.push_back(e);
    @(negedge clk);
    i_cmd_addr = addr; i_cmd_wr_rd = wr; i_cmd_byte_en = be; i_cmd_data = data;
    i_cmd_en = 1;
    aw_hi = 0; w_hi = 0; ar_hi = 0; lat = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      lat++;
      aw_hi += int'(o_awvalid); w_hi += int'(o_wvalid); ar_hi += int'(o_arvalid);
      if (c == 0) begin
        check("busy", o_cmd_status[0], 1);
        if (drop_early) i_cmd_en = 0;
      end
      if (o_cmd_ack) done = 1;
    end
    if (!done) check("ack_wait_expired", 0, 1);
    else begin
      i_cmd_en = 0;
      @(negedge clk);
      check(drop_early ? "ack_pulse" : "ack_release", {o_cmd_ack, o_cmd_error}, 2'b00);
    end
  endtask

  initial begin
    int aw_hi, w_hi, ar_hi, lat;
    exp_t e;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {o_cmd_ack, o_cmd_error, o_awvalid, o_wvalid, o_arvalid,
                       o_bready, o_rready, o_cmd_interrupt}, 8'h00);
    check("rst_status", o_cmd_status, 32'h0);
    check("rst_data", o_cmd_data, 32'h0);
    check("consts", {o_awsize, o_arsize, o_arlen, o_wlast, o_awid, o_wid, o_arid},
          {3'b010, 3'b010, 8'h00, 1'b1, 12'h000});
    @(negedge clk); rst = 1;

    // Zero-wait write
    e = '{err: 0, chk_data: 0, data: 0, status: 32'h0};
    run_cmd(1, 32'h10, 4'hF, 32'hDEADBEEF, e, 0, aw_hi, w_hi, ar_hi, lat);
    check("wr_latency_le4", lat <= 4, 1);

    // Zero-wait read
    cfg_rdata = 32'h12345678;
    e = '{err: 0, chk_data: 1, data: 32'h12345678, status: 32'h0};
    run_cmd(0, 32'h20, 4'hF, 32'h0, e, 0, aw_hi, w_hi, ar_hi, lat);
    check("rd_latency_le4", lat <= 4, 1);

    // AW held off for 5 cycles, W accepted at once
    cfg_aw_dly = 5;
    e = '{err: 0, chk_data: 0, data: 0, status: 32'h0};
    run_cmd(1, 32'h30, 4'h3, 32'hA5A50001, e, 0, aw_hi, w_hi, ar_hi, lat);
    check("awvalid_cycles", aw_hi, 6);
    check("wvalid_cycles", w_hi, 1);
    cfg_aw_dly = 0;

    // Read with SLVERR: berr + resp=2 in status
    cfg_rdata = 32'hBAD0BAD0; cfg_rresp = 2'b10;
    e = '{err: 1, chk_data: 1, data: 32'hBAD0BAD0, status: 32'h24};
    run_cmd(0, 32'h24, 4'hF, 32'h0, e, 0, aw_hi, w_hi, ar_hi, lat);
    cfg_rresp = 2'b00;

    // Write with DECERR, command dropped before ack
    cfg_bresp = 2'b11;
    e = '{err: 1, chk_data: 0, data: 0, status: 32'h34};
    run_cmd(1, 32'h44, 4'h6, 32'hCAFEF00D, e, 1, aw_hi, w_hi, ar_hi, lat);
    cfg_bresp = 2'b00;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    // AR never accepted: gives up after TMO cycles
    cfg_ar_never = 1;
    e = '{err: 1, chk_data: 1, data: 32'hBAD0BAD0, status: 32'h2};
    exp_q.push_back(e);
    @(negedge clk);
    i_cmd_addr = 32'h50; i_cmd_wr_rd = 0; i_cmd_en = 1;
    ar_hi = 0; lat = 0;
    while (!o_cmd_ack && lat < 100) begin
      @(negedge clk); lat++; ar_hi += int'(o_arvalid);
    end
    check("timeout_ack", o_cmd_ack, 1);
    check("timeout_arvalid_cycles", ar_hi, TMO);
    i_cmd_en = 0;
    @(negedge clk);
    check("timeout_release", {o_cmd_ack, o_arvalid}, 2'b00);
    cfg_ar_never = 0;
`else
    // Without the timeout a slow AR simply waits it out
    cfg_ar_dly = 20; cfg_rdata = 32'h0BADF00D;
    e = '{err: 0, chk_data: 1, data: 32'h0BADF00D, status: 32'h0};
    run_cmd(0, 32'h50, 4'hF, 32'h0, e, 0, aw_hi, w_hi, ar_hi, lat);
    check("slow_ar_cycles", ar_hi, 21);
    cfg_ar_dly = 0;
`endif

    // Reset in the middle of a write aborts without completion
    cfg_aw_dly = 10;
    exp_aw_q.push_back(32'h60);
    exp_w_q.push_back({4'hF, 32'h11112222});
    @(negedge clk);
    i_cmd_addr = 32'h60; i_cmd_wr_rd = 1; i_cmd_byte_en = 4'hF; i_cmd_data = 32'h11112222;
    i_cmd_en = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("abort_outputs", {o_cmd_ack, o_cmd_error, o_awvalid, o_wvalid, o_bready}, 5'b0);
    check("abort_status", o_cmd_status, 32'h0);
    i_cmd_en = 0;
    @(negedge clk);
    exp_aw_q.delete(); exp_w_q.delete();
    rst = 1; cfg_aw_dly = 0;

    // Recovery after reset
    cfg_rdata = 32'h5555AAAA;
    e = '{err: 0, chk_data: 1, data: 32'h5555AAAA, status: 32'h0};
    run_cmd(0, 32'h70, 4'hF, 32'h0, e, 0, aw_hi, w_hi, ar_hi, lat);

    // Interrupt flag follows inputs one cycle later
    i_interrupts = 32'h4;
    @(negedge clk);
    check("irq_set", {o_cmd_interrupt, o_cmd_status}, {1'b1, 32'h100});
    i_interrupts = 32'h0;
    @(negedge clk);
    check("irq_clear", {o_cmd_interrupt, o_cmd_status}, {1'b0, 32'h0});

    repeat (2) @(negedge clk);
    check("queues_drained", exp_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule
